// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes, owner ids, default widths.
package dmem_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'd0;
    localparam arb_state_t ARB_CPU  = 2'd1;
    localparam arb_state_t ARB_DMA  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/dmem_arb_beat_cnt.sv
// Burst beat counter: clears on ownership change, counts transfers, saturates at the limit.
module dmem_arb_beat_cnt #(
    parameter int MAX_BURST = 4,
    localparam int CW = $clog2(MAX_BURST) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign limit_o = (cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/loader port
// with registered ownership, a per-owner burst limit and round-robin tie-break.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              d_mem_write_en,
    output logic              d_mem_read,
    output logic [ADDR_W-1:0] d_mem_addr,
    output logic [DATA_W-1:0] d_mem_write_data,
    input  logic [DATA_W-1:0] d_mem_read_data
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       own_cpu, own_dma;
    logic       sel_req, sel_we;
    logic       limit;

    assign own_cpu = (state_q == ARB_CPU);
    assign own_dma = (state_q == ARB_DMA);
    assign cpu_gnt = own_cpu;
    assign dma_gnt = own_dma;
    assign cpu_stall = cpu_req & ~own_cpu;

    // Memory port follows the current owner; everything is zero while idle.
    always_comb begin
        sel_req          = 1'b0;
        sel_we           = 1'b0;
        d_mem_addr       = '0;
        d_mem_write_data = '0;
        if (own_cpu) begin
            sel_req          = cpu_req;
            sel_we           = cpu_we;
            d_mem_addr       = cpu_addr;
            d_mem_write_data = cpu_wdata;
        end else if (own_dma) begin
            sel_req          = dma_req;
            sel_we           = dma_we;
            d_mem_addr       = dma_addr;
            d_mem_write_data = dma_wdata;
        end
    end

    assign d_mem_write_en = sel_req & sel_we;
    assign d_mem_read     = sel_req & ~sel_we;
    assign cpu_rdata      = (own_cpu && d_mem_read) ? d_mem_read_data : '0;
    assign dma_rdata      = (own_dma && d_mem_read) ? d_mem_read_data : '0;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (cpu_req && dma_req) begin
                    state_d = (last_q == OWN_DMA) ? ARB_CPU : ARB_DMA;
                end else if (cpu_req) begin
                    state_d = ARB_CPU;
                end else if (dma_req) begin
                    state_d = ARB_DMA;
                end
            end
            ARB_CPU: begin
                if (!cpu_req || (dma_req && limit)) begin
                    state_d = dma_req ? ARB_DMA : ARB_IDLE;
                    last_d  = OWN_CPU;
                end
            end
            ARB_DMA: begin
                if (!dma_req || (cpu_req && limit)) begin
                    state_d = cpu_req ? ARB_CPU : ARB_IDLE;
                    last_d  = OWN_DMA;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    dmem_arb_beat_cnt #(
        .MAX_BURST(MAX_BURST)
    ) u_beat_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_d != state_q),
        .inc_i  (sel_req),
        .limit_o(limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            last_q  <= OWN_DMA;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory (DMEM[i]=i at init).
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_stall;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        d_mem_write_en, d_mem_read;
    logic [15:0] d_mem_addr, d_mem_write_data, d_mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];
    logic        mem_init = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i);
        end else if (d_mem_write_en) begin
            mem[d_mem_addr[7:0]] <= d_mem_write_data;
        end
    end
    assign d_mem_read_data = mem[d_mem_addr[7:0]];

    dmem_arbiter #(
        .DATA_W(16),
        .ADDR_W(16),
        .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .d_mem_write_en(d_mem_write_en), .d_mem_read(d_mem_read),
        .d_mem_addr(d_mem_addr), .d_mem_write_data(d_mem_write_data),
        .d_mem_read_data(d_mem_read_data)
    );

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic init_mem();
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0011; cpu_wdata = 16'h1234;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0022; dma_wdata = 16'h5678;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctl: got gnt/we/rd=%b want 0000",
                     {cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read});
        end
        checks++;
        if ({d_mem_addr, d_mem_write_data, cpu_rdata, dma_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h wd=%h crd=%h drd=%h want all 0",
                     d_mem_addr, d_mem_write_data, cpu_rdata, dma_rdata);
        end
        checks++;
        if (cpu_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b want 1", cpu_stall);
        end
        idle_inputs();
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_hold: cycle %0d got %b want 0000", i,
                         {cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        idle_inputs(); do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd3;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_stall} !== 2'b01) begin
            errors++;
            $display("FAIL read_wait: got gnt/stall=%b want 01", {cpu_gnt, cpu_stall});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, d_mem_read, d_mem_write_en, cpu_stall} !== 4'b1100) begin
            errors++;
            $display("FAIL read_grant: got gnt/rd/we/stall=%b want 1100",
                     {cpu_gnt, d_mem_read, d_mem_write_en, cpu_stall});
        end
        checks++;
        if (cpu_rdata !== 16'd3 || d_mem_addr !== 16'd3) begin
            errors++;
            $display("FAIL read_data: got rdata=%h addr=%h want 0003/0003", cpu_rdata, d_mem_addr);
        end
        @(posedge clk); #1 cpu_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_tie_break();
        idle_inputs(); do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd1;
        dma_req = 1; dma_we = 0; dma_addr = 16'd2;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b10 || cpu_rdata !== 16'd1 || dma_rdata !== 16'd0) begin
            errors++;
            $display("FAIL tie_first: got gnt=%b crd=%h drd=%h want 10/0001/0000",
                     {cpu_gnt, dma_gnt}, cpu_rdata, dma_rdata);
        end
        @(posedge clk); #1 cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, d_mem_write_en, d_mem_read} !== 3'b100) begin
            errors++;
            $display("FAIL tie_waste: got gnt/we/rd=%b want 100",
                     {cpu_gnt, d_mem_write_en, d_mem_read});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dma_gnt} !== 2'b01 || dma_rdata !== 16'd2) begin
            errors++;
            $display("FAIL tie_handover: got gnt=%b drd=%h want 01/0002", {cpu_gnt, dma_gnt}, dma_rdata);
        end
        @(posedge clk); #1 dma_req = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_burst_limit();
        int idx = 0, dma_beats = 0, beats_before_cpu = -1, bad = 0;
        logic dx, cx;
        idle_inputs(); init_mem(); do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 16'd0; dma_wdata = 16'hA0;
        cpu_we = 0; cpu_addr = 16'd7;
        for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
            @(negedge clk);
            dx = dma_gnt & dma_req;
            cx = cpu_gnt & cpu_req;
            if (cx && beats_before_cpu < 0) begin
                beats_before_cpu = dma_beats;
                checks++;
                if (cpu_rdata !== 16'd7 || dma_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_cpu_read: got rdata=%h dma_gnt=%b want 0007/0", cpu_rdata, dma_gnt);
                end
            end
            @(posedge clk); #1;
            if (dx) begin
                dma_beats++;
                idx++;
                if (idx < 6) begin
                    dma_addr = 16'(idx); dma_wdata = 16'(16'hA0 + idx);
                end else begin
                    dma_req = 0;
                end
                if (dma_beats == 1) cpu_req = 1;
            end
            if (cx) cpu_req = 0;
        end
        checks++;
        if (beats_before_cpu != MAXB) begin
            errors++;
            $display("FAIL burst_len: got %0d DMA beats before CPU want %0d", beats_before_cpu, MAXB);
        end
        checks++;
        if (idx != 6) begin
            errors++;
            $display("FAIL burst_done: got %0d DMA writes in budget want 6", idx);
        end
        for (int i = 0; i < 8; i++) begin
            if (mem[i] !== ((i < 6) ? 16'(16'hA0 + i) : 16'(i))) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL burst_mem: got %0d wrong words in DMEM[0..7] want 0 (A0..A5,6,7)", bad);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_owner_drop();
        int bad = 0;
        idle_inputs(); init_mem(); do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'd5;
        @(posedge clk); #1;
        cpu_req = 0; cpu_we = 1; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, d_mem_write_en, d_mem_read} !== 3'b100) begin
            errors++;
            $display("FAIL drop_waste: got gnt/we/rd=%b want 100", {cpu_gnt, d_mem_write_en, d_mem_read});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read} !== 4'b0000 || d_mem_addr !== 16'd0) begin
            errors++;
            $display("FAIL drop_idle: got gnt/we/rd=%b addr=%h want 0000/0000",
                     {cpu_gnt, dma_gnt, d_mem_write_en, d_mem_read}, d_mem_addr);
        end
        for (int i = 0; i < 16; i++) if (mem[i] !== 16'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drop_mem: got %0d modified words want 0", bad);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        idle_inputs(); init_mem(); do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 16'd2; dma_wdata = 16'h00FF;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({dma_gnt, d_mem_write_en} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre: got gnt/we=%b want 11", {dma_gnt, d_mem_write_en});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dma_gnt, d_mem_write_en} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_drop: got gnt/we=%b want 00", {dma_gnt, d_mem_write_en});
        end
        @(posedge clk); #1;
        checks++;
        if (mem[2] !== 16'd2) begin
            errors++;
            $display("FAIL rstmid_mem: got DMEM[2]=%h want 0002", mem[2]);
        end
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Reference: owner -1 none, 0 cpu, 1 dma; tenure counts transfers since the grant.
    task automatic test_random();
        logic [15:0] refm [256];
        logic        rq [2];
        logic        rw [2];
        logic [15:0] ra [2];
        logic [15:0] rd [2];
        int          owner = -1, last = 1, tenure = 0, nxt, bad = 0;
        logic        c_done = 0, d_done = 0;
        logic        e_we, e_rd;
        logic [15:0] e_addr, e_wd, e_rdat;
        idle_inputs(); init_mem(); do_reset();
        for (int i = 0; i < 256; i++) refm[i] = 16'(i);
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!cpu_req || c_done) begin
                cpu_req = ($urandom_range(0, 9) < 7); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            end
            if (!dma_req || d_done) begin
                dma_req = ($urandom_range(0, 9) < 7); dma_we = 1'($urandom_range(0, 1));
                dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
            end
            @(negedge clk);
            rq[0] = cpu_req; rw[0] = cpu_we; ra[0] = cpu_addr; rd[0] = cpu_wdata;
            rq[1] = dma_req; rw[1] = dma_we; ra[1] = dma_addr; rd[1] = dma_wdata;
            e_we = 0; e_rd = 0; e_addr = '0; e_wd = '0; e_rdat = '0;
            if (owner >= 0) begin
                e_we = rq[owner] && rw[owner];
                e_rd = rq[owner] && !rw[owner];
                e_addr = ra[owner];
                e_wd = rd[owner];
                if (e_rd) e_rdat = refm[ra[owner][7:0]];
            end
            checks++;
            if ({cpu_gnt, dma_gnt, cpu_stall} !== {owner == 0, owner == 1, rq[0] && owner != 0}) begin
                errors++;
                $display("FAIL rnd_gnt: cyc %0d got gnt/stall=%b want %b", cyc, {cpu_gnt, dma_gnt, cpu_stall},
                         {owner == 0, owner == 1, rq[0] && owner != 0});
            end
            checks++;
            if ({d_mem_write_en, d_mem_read, d_mem_addr, d_mem_write_data} !== {e_we, e_rd, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rnd_bus: cyc %0d got we=%b rd=%b a=%h wd=%h want we=%b rd=%b a=%h wd=%h", cyc,
                         d_mem_write_en, d_mem_read, d_mem_addr, d_mem_write_data, e_we, e_rd, e_addr, e_wd);
            end
            checks++;
            if ({cpu_rdata, dma_rdata} !== {(owner == 0) ? e_rdat : 16'h0, (owner == 1) ? e_rdat : 16'h0}) begin
                errors++;
                $display("FAIL rnd_rdata: cyc %0d got c=%h d=%h want owner %0d data %h", cyc,
                         cpu_rdata, dma_rdata, owner, e_rdat);
            end
            c_done = cpu_gnt & cpu_req;
            d_done = dma_gnt & dma_req;
            if (e_we) refm[e_addr[7:0]] = e_wd;
            if (owner < 0) begin
                if (rq[0] && rq[1]) nxt = 1 - last;
                else if (rq[0]) nxt = 0;
                else if (rq[1]) nxt = 1;
                else nxt = -1;
                tenure = 0;
            end else if (!rq[owner]) begin
                nxt = rq[1 - owner] ? 1 - owner : -1;
                last = owner; tenure = 0;
            end else if (rq[1 - owner] && tenure + 1 >= MAXB) begin
                nxt = 1 - owner;
                last = owner; tenure = 0;
            end else begin
                nxt = owner; tenure++;
            end
            owner = nxt;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rnd_mem: got %0d words differing from reference want 0", bad);
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        init_mem();
        test_reset();
        test_single_read();
        test_tie_break();
        test_burst_limit();
        test_owner_drop();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
